spi_minion_components_multi_sync: RTL and testbench



---
 rtl/spi_minion_sync_pkg.sv | 15 +
 rtl/spi_minion_components_sync_channel.sv | 67 ++++++
 rtl/spi_minion_components_multi_sync.sv | 48 ++++
 tb/tb_spi_minion_components_multi_sync.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_minion_sync_pkg.sv
// Shared constants and helpers for the multi-channel SPI minion input synchronizer.
package spi_minion_sync_pkg;

    // Largest stability window the filter counter is allowed to be sized for.
    localparam int MAX_FILTER = 255;

    // Width of the per-channel stability counter: enough to hold FILTER_CYCLES,
    // but never less than one bit so the register still exists when filtering is off.
    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_minion_components_sync_channel.sv
// One synchronizer channel: metastability flop chain, consecutive-cycle
// stability filter and registered edge detection.
module spi_minion_components_sync_channel
    import spi_minion_sync_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_,
    output logic out,
    output logic posedge_,
    output logic negedge_
);

    localparam int             CW         = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  FILTER_MAX = CW'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   f;
    logic                   fd;
    logic [CW-1:0]          cnt;

    // Shift the raw pin through the metastability chain; reset parks it at the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Accept a new level only after it has differed from the current one for
    // FILTER_CYCLES+1 consecutive edges; any return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            f   <= RESET_VALUE;
            cnt <= '0;
        end else if (s == f) begin
            cnt <= '0;
        end else if (cnt == FILTER_MAX) begin
            f   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the filtered level so edges are decoded purely from registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fd <= RESET_VALUE;
        end else begin
            fd <= f;
        end
    end

    assign out      = f;
    assign posedge_ = f & ~fd;
    assign negedge_ = ~f & fd;

endmodule

// File: rtl/spi_minion_components_multi_sync.sv
// Multi-channel synchronizer for SPI minion pins (SCLK, CS_N, MOSI, ...).
// Each channel is independent; edge_any flags a change on any channel.
module spi_minion_components_multi_sync
    import spi_minion_sync_pkg::*;
#(
    parameter int                NUM_CH        = 3,
    parameter int                SYNC_STAGES   = 2,
    parameter int                FILTER_CYCLES = 0,
    parameter logic [NUM_CH-1:0] RESET_VALUE   = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] in_,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] posedge_,
    output logic [NUM_CH-1:0] negedge_,
    output logic              edge_any
);

    // Reject configurations the channel logic is not built for.
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("NUM_CH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
        $error("FILTER_CYCLES must be in 0..MAX_FILTER");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        spi_minion_components_sync_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VALUE   (RESET_VALUE[c])
        ) u_channel (
            .clk      (clk),
            .reset    (reset),
            .in_      (in_[c]),
            .out      (out[c]),
            .posedge_ (posedge_[c]),
            .negedge_ (negedge_[c])
        );
    end

    assign edge_any = |(posedge_ | negedge_);

endmodule

// File: tb/tb_spi_minion_components_multi_sync.sv
// Bench for the multi-channel synchronizer. Four configurations share one
// input bus; a history-based model predicts every output every cycle.
module tb_spi_minion_components_multi_sync;

    localparam int N_INST = 4;
    localparam int MAXD   = 6;

    localparam int         S_CFG  [N_INST] = '{2, 2, 4, 3};
    localparam int         F_CFG  [N_INST] = '{0, 3, 0, 2};
    localparam logic [2:0] RV_CFG [N_INST] = '{3'b100, 3'b000, 3'b000, 3'b010};

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_;
    logic [2:0] out  [N_INST];
    logic [2:0] pos  [N_INST];
    logic [2:0] neg  [N_INST];
    logic       any  [N_INST];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        spi_minion_components_multi_sync #(
            .NUM_CH        (3),
            .SYNC_STAGES   (S_CFG[g]),
            .FILTER_CYCLES (F_CFG[g]),
            .RESET_VALUE   (RV_CFG[g])
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .in_      (in_),
            .out      (out[g]),
            .posedge_ (pos[g]),
            .negedge_ (neg[g]),
            .edge_any (any[g])
        );
    end

    // Model state: history of pin values captured at each edge (index 0 newest),
    // the accepted level and its value one cycle earlier.
    logic [2:0] m_hist [N_INST][MAXD];
    logic [2:0] m_f    [N_INST];
    logic [2:0] m_fd   [N_INST];
    bit         model_valid = 1'b0;

    // A level is accepted once the value seen after the chain has been the
    // opposite of the current level on FILTER_CYCLES+1 consecutive edges.
    always @(posedge clk) begin
        automatic logic [2:0] nf;
        automatic bit         persisted;
        for (int i = 0; i < N_INST; i++) begin
            if (reset) begin
                m_f[i]  <= RV_CFG[i];
                m_fd[i] <= RV_CFG[i];
                for (int d = 0; d < MAXD; d++) m_hist[i][d] <= RV_CFG[i];
            end else begin
                nf = m_f[i];
                for (int c = 0; c < 3; c++) begin
                    persisted = 1'b1;
                    for (int j = 0; j <= F_CFG[i]; j++) begin
                        if (m_hist[i][S_CFG[i]-1+j][c] == m_f[i][c]) persisted = 1'b0;
                    end
                    if (persisted) nf[c] = ~m_f[i][c];
                end
                m_fd[i] <= m_f[i];
                m_f[i]  <= nf;
                for (int d = MAXD - 1; d > 0; d--) m_hist[i][d] <= m_hist[i][d-1];
                m_hist[i][0] <= in_;
            end
        end
        if (reset) model_valid <= 1'b1;
    end

    // Single comparison point used by both the per-cycle compare and literal pins.
    task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the pin bus at a falling edge and hold it for a number of cycles.
    task automatic applyStimulus(input logic [2:0] value, input int cycles);
        in_ = value;
        repeat (cycles) @(negedge clk);
    endtask

    // Compare every instance against the model on each falling edge once the model is seeded.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < N_INST; i++) begin
                checkOutput($sformatf("inst%0d out", i), out[i], m_f[i]);
                checkOutput($sformatf("inst%0d posedge_", i), pos[i], m_f[i] & ~m_fd[i]);
                checkOutput($sformatf("inst%0d negedge_", i), neg[i], ~m_f[i] & m_fd[i]);
                checkOutput($sformatf("inst%0d edge_any", i), {2'b00, any[i]},
                            {2'b00, |((m_f[i] & ~m_fd[i]) | (~m_f[i] & m_fd[i]))});
            end
        end
    end

    // Pulse and level tallies for the glitch and toggle phases.
    bit glitch_phase = 1'b0;
    bit toggle_phase = 1'b0;
    int g_pos1 = 0, g_neg1 = 0, g_high1 = 0;
    int g_pos2 = 0, g_neg2 = 0, g_high2 = 0;
    int g_pos3 = 0;
    int t_any1 = 0, t_any3 = 0;

    // Accumulate the tallies away from the active edge.
    always @(negedge clk) begin
        if (glitch_phase) begin
            if (pos[1][0]) g_pos1++;
            if (neg[1][0]) g_neg1++;
            if (out[1][0]) g_high1++;
            if (pos[2][0]) g_pos2++;
            if (neg[2][0]) g_neg2++;
            if (out[2][0]) g_high2++;
            if (pos[3][0]) g_pos3++;
        end
        if (toggle_phase) begin
            if (any[1]) t_any1++;
            if (any[3]) t_any3++;
        end
    end

    // Directed scenario with hand-computed expectations at key points.
    initial begin
        reset = 1'b1;
        in_   = 3'b000;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset inst0 out", out[0], 3'b100);
        checkOutput("reset inst0 edges", pos[0] | neg[0], 3'b000);
        checkOutput("reset inst3 out", out[3], 3'b010);

        // Release reset with 3'b011 on the pins; inst0 (S=2,F=0) responds after the third edge.
        reset = 1'b0;
        applyStimulus(3'b011, 1);
        checkOutput("post-reset e1 inst0 out", out[0], 3'b100);
        checkOutput("post-reset e1 inst0 any", {2'b00, any[0]}, 3'b000);
        applyStimulus(3'b011, 1);
        checkOutput("post-reset e2 inst0 out", out[0], 3'b100);
        applyStimulus(3'b011, 1);
        checkOutput("e3 inst0 out", out[0], 3'b011);
        checkOutput("e3 inst0 posedge_", pos[0], 3'b011);
        checkOutput("e3 inst0 negedge_", neg[0], 3'b100);
        checkOutput("e3 inst0 edge_any", {2'b00, any[0]}, 3'b001);
        applyStimulus(3'b011, 1);
        checkOutput("e4 inst0 posedge_", pos[0], 3'b000);
        applyStimulus(3'b011, 1);
        checkOutput("e5 inst1 out", out[1], 3'b000);
        applyStimulus(3'b011, 1);
        checkOutput("e6 inst1 out", out[1], 3'b011);
        checkOutput("e6 inst1 posedge_", pos[1], 3'b011);

        applyStimulus(3'b000, 12);

        // Pulses of width 1..4 on channel 0, each followed by a quiet gap.
        $display("[TB] glitch widths");
        glitch_phase = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            applyStimulus(3'b001, w);
            applyStimulus(3'b000, 10);
        end
        glitch_phase = 1'b0;
        checkOutput("glitch inst1 pos count", g_pos1[2:0], 3'd1);
        checkOutput("glitch inst1 neg count", g_neg1[2:0], 3'd1);
        checkOutput("glitch inst1 high cycles", g_high1[2:0], 3'd4);
        checkOutput("glitch inst2 pos count", g_pos2[2:0], 3'd4);
        checkOutput("glitch inst2 neg count", g_neg2[2:0], 3'd4);
        checkOutput("glitch inst2 high cycles", g_high2[3:1], 3'd5);
        checkOutput("glitch inst3 pos count", g_pos3[2:0], 3'd2);

        // Latency of the 4-stage, unfiltered instance.
        $display("[TB] latency");
        applyStimulus(3'b001, 4);
        checkOutput("latency inst2 before", out[2], 3'b000);
        applyStimulus(3'b001, 1);
        checkOutput("latency inst2 out", out[2], 3'b001);
        checkOutput("latency inst2 posedge_", pos[2], 3'b001);
        applyStimulus(3'b000, 12);

        // Reset arrives while inst1 is two counts into accepting a change.
        $display("[TB] reset mid-count");
        applyStimulus(3'b001, 4);
        reset = 1'b1;
        applyStimulus(3'b001, 2);
        checkOutput("midreset inst1 out", out[1], 3'b000);
        checkOutput("midreset inst0 out", out[0], 3'b100);
        checkOutput("midreset inst1 any", {2'b00, any[1]}, 3'b000);
        reset = 1'b0;
        applyStimulus(3'b001, 5);
        checkOutput("after reset inst1 still low", out[1], 3'b000);
        applyStimulus(3'b001, 1);
        checkOutput("after reset inst1 out", out[1], 3'b001);
        applyStimulus(3'b000, 12);

        // Every-cycle toggling must never get through a filter of 2 or more.
        $display("[TB] toggle");
        toggle_phase = 1'b1;
        for (int k = 0; k < 50; k++) begin
            applyStimulus((k % 2 == 0) ? 3'b111 : 3'b000, 1);
        end
        applyStimulus(3'b000, 10);
        toggle_phase = 1'b0;
        checkOutput("toggle inst1 edge_any count", t_any1[2:0], 3'd0);
        checkOutput("toggle inst3 edge_any count", t_any3[2:0], 3'd0);
        checkOutput("toggle inst3 out", out[3], 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
